sp_bram_bytewe_pipelined: RTL and testbench

//  Parametrised single-port block RAM: NUM_BYTES lanes of BYTE_WIDTH bits per word, per-lane write enable.

---
 rtl/sp_bram_pkg.sv | 36 +++
 rtl/sp_bram_out_stage.sv | 37 +++
 rtl/sp_bram_bytewe_pipelined.sv | 96 +++++++++
 tb/tb_sp_bram_bytewe_pipelined.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sp_bram_pkg.sv
// +--------------------------------------------------------------------------+
// | sp_bram_pkg                                                              |
// | Write-mode constants and byte-lane merge helper for sp_bram_* RAMs.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package sp_bram_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  localparam int c_MAX_W     = 256;
  localparam int c_MAX_LANES = 32;

  // Lane k of the result comes from new_word when lane_we[k] is set, else from old_word.
  function automatic logic [c_MAX_W-1:0] lane_merge(
    input logic [c_MAX_W-1:0]     old_word,
    input logic [c_MAX_W-1:0]     new_word,
    input logic [c_MAX_LANES-1:0] lane_we,
    input int                     lane_bits
  );
    logic [c_MAX_W-1:0]     merged;
    logic [c_MAX_LANES-1:0] sel;
    merged = old_word;
    for (int i = 0; i < c_MAX_W; i++) begin
      sel = lane_we >> (i / lane_bits);
      if (sel[0]) merged[i] = new_word[i];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sp_bram_out_stage.sv
// +--------------------------------------------------------------------------+
// | sp_bram_out_stage                                                        |
// | Optional read-data/valid output register, shifts every cycle.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sp_bram_out_stage #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);

  logic [WIDTH-1:0] r_dout;
  logic             r_vout;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout <= '0;
      r_vout <= 1'b0;
    end else begin
      r_dout <= din;
      r_vout <= vin;
    end
  end

  assign dout = r_dout;
  assign vout = r_vout;

endmodule

`default_nettype wire

// File: rtl/sp_bram_bytewe_pipelined.sv
// +--------------------------------------------------------------------------+
// | sp_bram_bytewe_pipelined                                                 |
// | Single-port byte-lane-writable block RAM, READ_FIRST/WRITE_FIRST/        |
// | NO_CHANGE, valid-tracked read data. SP_BRAM_OUT_REG_EN adds an output    |
// | register stage (latency 2 instead of 1).                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module sp_bram_bytewe_pipelined
  import sp_bram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int SIZE       = 512,
  parameter int BYTE_WIDTH = 8,
  parameter int NUM_BYTES  = 2,
  parameter int WRITE_MODE = WM_READ_FIRST
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            en,
  input  logic [NUM_BYTES-1:0]            we,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [NUM_BYTES*BYTE_WIDTH-1:0] DI,
  output logic [NUM_BYTES*BYTE_WIDTH-1:0] DO,
  output logic                            dvalid
);

  localparam int                c_W    = NUM_BYTES * BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_SIZE = (ADDR_WIDTH + 1)'(SIZE);

  logic [c_W-1:0] r_mem [0:SIZE-1];
  logic [c_W-1:0] r_mem_q;
  logic [c_W-1:0] r_do_hold;
  logic           r_load;
  logic           r_oob;
  logic           r_dvalid;

  logic [c_W-1:0] w_do;
  logic           w_in_range;
  logic           w_nc_block;

  assign w_in_range = ({1'b0, addr} < c_SIZE);
  assign w_nc_block = (WRITE_MODE == WM_NO_CHANGE) && (|we);

  // Array process: no reset and no combinational read path, so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (RST_N && en && w_in_range) begin
      if (WRITE_MODE == WM_WRITE_FIRST) begin
        r_mem_q <= c_W'(lane_merge(c_MAX_W'(r_mem[addr]), c_MAX_W'(DI),
                                   c_MAX_LANES'(we), BYTE_WIDTH));
      end else if (!w_nc_block) begin
        r_mem_q <= r_mem[addr];
      end
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (we[k]) r_mem[addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= DI[k*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_load    <= 1'b0;
      r_oob     <= 1'b0;
      r_dvalid  <= 1'b0;
      r_do_hold <= '0;
    end else begin
      r_do_hold <= w_do;
      r_load    <= en && w_in_range && !w_nc_block;
      r_oob     <= en && !w_in_range;
      r_dvalid  <= en && (!w_in_range || !w_nc_block);
    end
  end

  // Out-of-range reads return zero; cycles without a fresh load repeat the last DO.
  assign w_do = r_oob ? '0 : (r_load ? r_mem_q : r_do_hold);

`ifdef SP_BRAM_OUT_REG_EN
  sp_bram_out_stage #(
    .WIDTH (c_W)
  ) u_out_stage (
    .CLK   (CLK),
    .RST_N (RST_N),
    .din   (w_do),
    .vin   (r_dvalid),
    .dout  (DO),
    .vout  (dvalid)
  );
`else
  assign DO     = w_do;
  assign dvalid = r_dvalid;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sp_bram_bytewe_pipelined.sv
// Bench: three RAM instances (one per write mode) on shared stimulus, checked against a
// behavioural model every cycle plus literal expectations for the directed scenarios.
`default_nettype none

module tb_sp_bram_bytewe_pipelined;
  import sp_bram_pkg::*;

`ifdef SP_BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int SIZE = 500;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  we = 2'b00;
  logic [8:0]  addr = '0;
  logic [15:0] DI = '0;
  logic [15:0] dut_do [3];
  logic        dut_dv [3];

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  // model: array plus per-mode first/second stage results
  logic [15:0] mmem [0:SIZE-1];
  logic [15:0] m_do1 [3];
  logic        m_v1  [3];
  logic [15:0] m_do2 [3];
  logic        m_v2  [3];

  always #5 CLK = ~CLK;

  sp_bram_bytewe_pipelined #(.ADDR_WIDTH(9), .SIZE(SIZE), .BYTE_WIDTH(8), .NUM_BYTES(2),
    .WRITE_MODE(WM_READ_FIRST)) u_rf (
    .CLK(CLK), .RST_N(RST_N), .en(en), .we(we), .addr(addr), .DI(DI),
    .DO(dut_do[0]), .dvalid(dut_dv[0]));
  sp_bram_bytewe_pipelined #(.ADDR_WIDTH(9), .SIZE(SIZE), .BYTE_WIDTH(8), .NUM_BYTES(2),
    .WRITE_MODE(WM_WRITE_FIRST)) u_wf (
    .CLK(CLK), .RST_N(RST_N), .en(en), .we(we), .addr(addr), .DI(DI),
    .DO(dut_do[1]), .dvalid(dut_dv[1]));
  sp_bram_bytewe_pipelined #(.ADDR_WIDTH(9), .SIZE(SIZE), .BYTE_WIDTH(8), .NUM_BYTES(2),
    .WRITE_MODE(WM_NO_CHANGE)) u_nc (
    .CLK(CLK), .RST_N(RST_N), .en(en), .we(we), .addr(addr), .DI(DI),
    .DO(dut_do[2]), .dvalid(dut_dv[2]));

  initial begin
    for (int m = 0; m < 3; m++) begin
      m_do1[m] = '0; m_v1[m] = 1'b0; m_do2[m] = '0; m_v2[m] = 1'b0;
    end
  end

  function automatic logic [15:0] exp_do(input int m);
    return (LAT == 2) ? m_do2[m] : m_do1[m];
  endfunction

  function automatic logic exp_v(input int m);
    return (LAT == 2) ? m_v2[m] : m_v1[m];
  endfunction

  // Model of one rising edge, evaluated from the inputs that were presented to it.
  task automatic model_edge();
    logic [15:0] old_w, mask, merged;
    if (!RST_N) begin
      for (int m = 0; m < 3; m++) begin
        m_do1[m] = '0; m_v1[m] = 1'b0; m_do2[m] = '0; m_v2[m] = 1'b0;
      end
      return;
    end
    for (int m = 0; m < 3; m++) begin
      m_do2[m] = m_do1[m];
      m_v2[m]  = m_v1[m];
    end
    if (!en) begin
      for (int m = 0; m < 3; m++) m_v1[m] = 1'b0;
    end else if (int'(addr) >= SIZE) begin
      for (int m = 0; m < 3; m++) begin
        m_v1[m] = 1'b1; m_do1[m] = '0;
      end
    end else begin
      old_w  = mmem[addr];
      mask   = {{8{we[1]}}, {8{we[0]}}};
      merged = (old_w & ~mask) | (DI & mask);
      m_do1[0] = old_w;  m_v1[0] = 1'b1;
      m_do1[1] = merged; m_v1[1] = 1'b1;
      if (we != 2'b00) m_v1[2] = 1'b0;
      else begin
        m_do1[2] = old_w; m_v1[2] = 1'b1;
      end
      mmem[addr] = merged;
    end
  endtask

  task automatic step(input logic e, input logic [1:0] w, input int a,
                      input logic [15:0] d, input logic r);
    @(negedge CLK);
    #1;
    RST_N = r; en = e; we = w; addr = a[8:0]; DI = d;
    @(posedge CLK);
    #1;
    model_edge();
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 0, 16'h0000, 1'b1);
  endtask

  task automatic lit(input string nm, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge CLK) begin
    if (chk_on) begin
      for (int m = 0; m < 3; m++) begin
        n_cmp++;
        if (dut_do[m] !== exp_do(m) || dut_dv[m] !== exp_v(m)) begin
          n_bad++;
          $display("FAIL cycle_compare mode=%0d t=%0t: DO=%h dvalid=%b, required DO=%h dvalid=%b",
                   m, $time, dut_do[m], dut_dv[m], exp_do(m), exp_v(m));
        end
      end
    end
  end

  initial begin
    @(posedge CLK);
    #1;
    chk_on = 1'b1;
    step(1'b0, 2'b00, 0, 16'h0000, 1'b0);
    for (int m = 0; m < 3; m++) begin
      lit("reset_do", dut_do[m], 16'h0000);
      lit("reset_dvalid", 16'(dut_dv[m]), 16'h0000);
    end

    // fill the working region so every read is defined
    for (int a = 0; a < 16; a++) step(1'b1, 2'b11, a, 16'($urandom), 1'b1);
    step(1'b1, 2'b11, 5, 16'h1234, 1'b1);
    step(1'b1, 2'b11, 2, 16'h0BEE, 1'b1);

    // reset held with an active write request: no write may land
    repeat (3) step(1'b1, 2'b11, 5, 16'hFFFF, 1'b0);
    for (int m = 0; m < 3; m++) begin
      lit("rst_hold_do", dut_do[m], 16'h0000);
      lit("rst_hold_dvalid", 16'(dut_dv[m]), 16'h0000);
    end
    idle();
    step(1'b1, 2'b00, 5, 16'h0000, 1'b1);
    if (LAT == 2) idle();
    for (int m = 0; m < 3; m++) lit("rst_no_write_addr5", dut_do[m], 16'h1234);

    // byte lanes
    step(1'b1, 2'b11, 3, 16'hA1B2, 1'b1);
    step(1'b1, 2'b01, 3, 16'hC3D4, 1'b1);
    step(1'b1, 2'b00, 3, 16'h0000, 1'b1);
    if (LAT == 2) idle();
    for (int m = 0; m < 3; m++) begin
      lit("lane_merge_do", dut_do[m], 16'hA1D4);
      lit("lane_merge_dvalid", 16'(dut_dv[m]), 16'h0001);
    end

    // write modes
    step(1'b1, 2'b11, 7, 16'h1111, 1'b1);
    step(1'b1, 2'b00, 3, 16'h0000, 1'b1);
    step(1'b1, 2'b11, 7, 16'h2222, 1'b1);
    if (LAT == 2) idle();
    lit("read_first_do", dut_do[0], 16'h1111);
    lit("read_first_dvalid", 16'(dut_dv[0]), 16'h0001);
    lit("write_first_do", dut_do[1], 16'h2222);
    lit("write_first_dvalid", 16'(dut_dv[1]), 16'h0001);
    lit("no_change_do", dut_do[2], 16'hA1D4);
    lit("no_change_dvalid", 16'(dut_dv[2]), 16'h0000);

    // back-to-back same address
    step(1'b1, 2'b11, 0, 16'h5A5A, 1'b1);
    step(1'b1, 2'b00, 0, 16'h0000, 1'b1);
    if (LAT == 2) idle();
    for (int m = 0; m < 3; m++) lit("b2b_do", dut_do[m], 16'h5A5A);
    for (int i = 0; i < 16; i++)
      step(1'b1, (i % 2 == 0) ? 2'($urandom_range(1, 3)) : 2'b00, (i / 2) % 2, 16'($urandom), 1'b1);

    // out of range, then idle hold
    step(1'b1, 2'b11, 510, 16'hFFFF, 1'b1);
    if (LAT == 2) idle();
    for (int m = 0; m < 3; m++) begin
      lit("oob_do", dut_do[m], 16'h0000);
      lit("oob_dvalid", 16'(dut_dv[m]), 16'h0001);
    end
    step(1'b1, 2'b00, 3, 16'h0000, 1'b1);
    idle();
    if (LAT == 2) idle();
    for (int m = 0; m < 3; m++) begin
      lit("idle_hold_do", dut_do[m], 16'hA1D4);
      lit("idle_dvalid", 16'(dut_dv[m]), 16'h0000);
    end

    // reset while a read is in flight
    step(1'b1, 2'b00, 2, 16'h0000, 1'b1);
    step(1'b0, 2'b00, 0, 16'h0000, 1'b0);
    lit("midrst_dvalid", 16'(dut_dv[0]), 16'h0000);
    idle();
    idle();
    for (int m = 0; m < 3; m++) lit("midrst_after_dvalid", 16'(dut_dv[m]), 16'h0000);
    step(1'b1, 2'b00, 2, 16'h0000, 1'b1);
    if (LAT == 2) idle();
    for (int m = 0; m < 3; m++) begin
      lit("midrst_mem_intact", dut_do[m], 16'h0BEE);
      lit("midrst_read_dvalid", 16'(dut_dv[m]), 16'h0001);
    end

    // randomized traffic, including occasional resets and out-of-range addresses
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom),
           ($urandom_range(0, 9) == 0) ? 500 + $urandom_range(0, 11) : $urandom_range(0, 15),
           16'($urandom), $urandom_range(0, 99) != 0);
    end
    idle();
    @(negedge CLK);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
